// File: rtl/ruler_search_sequencer.sv
// ruler_search_sequencer
//   Top-level controller for the optimal Golomb ruler search. It activates
//   one mark counter at a time. Each invocation receives an index, a start
//   value and the current length limit. The controller consumes each
//   verdict, records every complete ruler it finds, and tightens the limit
//   after each one.
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous, active-low reset
//   start            begin a search (honoured only in IDLE or DONE)
//   mc_ready         ready of the currently enabled mark counter
//   mc_next_enabled  next mark index reported by the active counter
//   mc_next_start    next start value reported by the active counter
//   marks_flat       current mark positions, mark k at [k*VW +: VW]
//   enabled          index of the active mark
//   start_value      start value handed to the active mark
//   request          one-cycle take-control pulse
//   limit            current exclusive length bound
//   found            one-cycle pulse when a complete ruler is recorded
//   found_length     length of the last ruler found
//   busy             search in progress
//   done             search exhausted (held until start or reset)
//   err              protocol violation (held until start or reset)
//   steps            completed counter invocations, saturating
module ruler_search_sequencer #(
   parameter int NUM_MARKS  = 5,
   parameter int VW         = 8,
   parameter int LW         = 4,
   parameter int INIT_LIMIT = 12
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    mc_ready,
   input  logic [LW-1:0]           mc_next_enabled,
   input  logic [VW-1:0]           mc_next_start,
   input  logic [NUM_MARKS*VW-1:0] marks_flat,
   output logic [LW-1:0]           enabled,
   output logic [VW-1:0]           start_value,
   output logic                    request,
   output logic [VW-1:0]           limit,
   output logic                    found,
   output logic [VW-1:0]           found_length,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [31:0]             steps
);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] ISSUE      = 3'd1;
   localparam logic [2:0] WAIT_BUSY  = 3'd2;
   localparam logic [2:0] WAIT_READY = 3'd3;
   localparam logic [2:0] DONE       = 3'd4;

   localparam logic [LW-1:0] MARK_CNT  = LW'(NUM_MARKS);
   localparam logic [LW-1:0] LAST_MARK = LW'(NUM_MARKS - 1);
   localparam logic [VW-1:0] LIMIT_0   = VW'(INIT_LIMIT);

   logic [2:0]    state;
   logic [VW-1:0] last_mark_pos;

   // Only the outermost mark defines a ruler's length; the others are
   // read solely by the counters.
   logic unused_inner_marks;

   assign last_mark_pos      = marks_flat[(NUM_MARKS-1)*VW +: VW];
   assign unused_inner_marks = ^marks_flat[(NUM_MARKS-1)*VW-1:0];

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= IDLE;
         enabled      <= '0;
         start_value  <= '0;
         request      <= 1'b0;
         limit        <= LIMIT_0;
         found        <= 1'b0;
         found_length <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         steps        <= '0;
      end else begin
         // request and found are single-cycle strobes
         request <= 1'b0;
         found   <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  enabled      <= LW'(1);
                  start_value  <= VW'(1);
                  limit        <= LIMIT_0;
                  steps        <= '0;
                  found_length <= '0;
                  done         <= 1'b0;
                  err          <= 1'b0;
                  busy         <= 1'b1;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               request <= 1'b1;
               state   <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               // counter acknowledges by dropping ready; no timeout by design
               if (!mc_ready) state <= WAIT_READY;
            end
            WAIT_READY: begin
               if (mc_ready) begin
                  steps <= sat_inc(steps);
                  if (mc_next_enabled == '0) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else if (mc_next_enabled == MARK_CNT) begin
                     // complete ruler: it becomes the new exclusive bound and
                     // the last mark keeps climbing from the reported start
                     found        <= 1'b1;
                     found_length <= last_mark_pos;
                     limit        <= last_mark_pos;
                     enabled      <= LAST_MARK;
                     start_value  <= mc_next_start;
                     state        <= ISSUE;
                  end else if (mc_next_enabled < MARK_CNT) begin
                     enabled     <= mc_next_enabled;
                     start_value <= mc_next_start;
                     state       <= ISSUE;
                  end else begin
                     err   <= 1'b1;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ruler_search_sequencer.sv
module tb_ruler_search_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        mc_ready;
   logic [3:0]  mc_next_enabled;
   logic [7:0]  mc_next_start;
   logic [39:0] marks_flat;
   logic [3:0]  enabled;
   logic [7:0]  start_value;
   logic        request;
   logic [7:0]  limit;
   logic        found;
   logic [7:0]  found_length;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] steps;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   ruler_search_sequencer #(
      .NUM_MARKS (5),
      .VW        (8),
      .LW        (4),
      .INIT_LIMIT(12)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .mc_ready       (mc_ready),
      .mc_next_enabled(mc_next_enabled),
      .mc_next_start  (mc_next_start),
      .marks_flat     (marks_flat),
      .enabled        (enabled),
      .start_value    (start_value),
      .request        (request),
      .limit          (limit),
      .found          (found),
      .found_length   (found_length),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .steps          (steps)
   );

   typedef struct {
      logic [3:0]  n;
      logic [7:0]  s;
      logic [7:0]  m4;
      logic [3:0]  e_en;
      logic [7:0]  e_sv;
      logic        e_found;
      logic [7:0]  e_flen;
      logic [7:0]  e_lim;
      logic        e_busy;
      logic        e_done;
      logic        e_err;
      logic [31:0] e_steps;
      logic        e_req;
   } vec_t;

   vec_t vecs[7];
   vec_t v_err;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One counter invocation starting from WAIT_BUSY with request already low.
   task automatic run_vec(input vec_t v, input int idx);
      string p;
      p = $sformatf("v%0d", idx);
      mc_ready = 1'b0;
      tick();
      mc_next_enabled = v.n;
      mc_next_start   = v.s;
      marks_flat      = {v.m4, 8'd3, 8'd2, 8'd1, 8'd0};
      mc_ready        = 1'b1;
      tick();
      chk({p, ".enabled"}, 32'(enabled), 32'(v.e_en));
      chk({p, ".start_value"}, 32'(start_value), 32'(v.e_sv));
      chk({p, ".found"}, 32'(found), 32'(v.e_found));
      chk({p, ".found_length"}, 32'(found_length), 32'(v.e_flen));
      chk({p, ".limit"}, 32'(limit), 32'(v.e_lim));
      chk({p, ".busy"}, 32'(busy), 32'(v.e_busy));
      chk({p, ".done"}, 32'(done), 32'(v.e_done));
      chk({p, ".err"}, 32'(err), 32'(v.e_err));
      chk({p, ".steps"}, steps, v.e_steps);
      chk({p, ".req_r"}, 32'(request), 32'd0);
      tick();
      chk({p, ".req_r1"}, 32'(request), 32'(v.e_req));
      chk({p, ".found_off"}, 32'(found), 32'd0);
      tick();
      chk({p, ".req_r2"}, 32'(request), 32'd0);
   endtask

   // start -> ISSUE -> request pulse -> WAIT_BUSY
   task automatic launch(input string name);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({name, ".enabled"}, 32'(enabled), 32'd1);
      chk({name, ".start_value"}, 32'(start_value), 32'd1);
      chk({name, ".limit"}, 32'(limit), 32'd12);
      chk({name, ".steps"}, steps, 32'd0);
      chk({name, ".busy"}, 32'(busy), 32'd1);
      chk({name, ".done"}, 32'(done), 32'd0);
      chk({name, ".err"}, 32'(err), 32'd0);
      chk({name, ".found_length"}, 32'(found_length), 32'd0);
      chk({name, ".req0"}, 32'(request), 32'd0);
      tick();
      chk({name, ".req1"}, 32'(request), 32'd1);
      tick();
      chk({name, ".req2"}, 32'(request), 32'd0);
   endtask

   initial begin
      //            n     s      m4     en    sv     fnd   flen   lim    bsy   dn    er    steps  req
      vecs[0] = '{4'd2, 8'd4,  8'd0,  4'd2, 8'd4,  1'b0, 8'd0,  8'd12, 1'b1, 1'b0, 1'b0, 32'd1, 1'b1};
      vecs[1] = '{4'd3, 8'd7,  8'd0,  4'd3, 8'd7,  1'b0, 8'd0,  8'd12, 1'b1, 1'b0, 1'b0, 32'd2, 1'b1};
      vecs[2] = '{4'd5, 8'd12, 8'd11, 4'd4, 8'd12, 1'b1, 8'd11, 8'd11, 1'b1, 1'b0, 1'b0, 32'd3, 1'b1};
      vecs[3] = '{4'd4, 8'd9,  8'd11, 4'd4, 8'd9,  1'b0, 8'd11, 8'd11, 1'b1, 1'b0, 1'b0, 32'd4, 1'b1};
      vecs[4] = '{4'd1, 8'd3,  8'd11, 4'd1, 8'd3,  1'b0, 8'd11, 8'd11, 1'b1, 1'b0, 1'b0, 32'd5, 1'b1};
      vecs[5] = '{4'd5, 8'd10, 8'd9,  4'd4, 8'd10, 1'b1, 8'd9,  8'd9,  1'b1, 1'b0, 1'b0, 32'd6, 1'b1};
      vecs[6] = '{4'd0, 8'd0,  8'd9,  4'd4, 8'd10, 1'b0, 8'd9,  8'd9,  1'b0, 1'b1, 1'b0, 32'd7, 1'b0};
      v_err   = '{4'd9, 8'd5,  8'd7,  4'd1, 8'd1,  1'b0, 8'd0,  8'd12, 1'b0, 1'b1, 1'b1, 32'd1, 1'b0};

      // reset with arbitrary inputs
      reset           = 1'b0;
      start           = 1'b1;
      mc_ready        = 1'b1;
      mc_next_enabled = 4'd3;
      mc_next_start   = 8'd77;
      marks_flat      = 40'hAB_CD_EF_12_34;
      tick();
      tick();
      chk("rst.enabled", 32'(enabled), 32'd0);
      chk("rst.start_value", 32'(start_value), 32'd0);
      chk("rst.request", 32'(request), 32'd0);
      chk("rst.limit", 32'(limit), 32'd12);
      chk("rst.found", 32'(found), 32'd0);
      chk("rst.found_length", 32'(found_length), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.err", 32'(err), 32'd0);
      chk("rst.steps", steps, 32'd0);
      start = 1'b0;
      reset = 1'b1;
      tick();
      chk("idle.busy", 32'(busy), 32'd0);

      // descend / leaf / exhaustion table
      launch("start1");
      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("done.no_req", 32'(request), 32'd0);
         chk("done.hold", 32'(done), 32'd1);
      end

      // restart from DONE, then start during WAIT_READY is ignored
      launch("start2");
      mc_ready = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ign.steps", steps, 32'd0);
      chk("ign.enabled", 32'(enabled), 32'd1);
      chk("ign.busy", 32'(busy), 32'd1);
      tick();
      chk("ign.request", 32'(request), 32'd0);
      // still waiting for ready: now return an out-of-range index
      mc_next_enabled = v_err.n;
      mc_next_start   = v_err.s;
      mc_ready        = 1'b1;
      tick();
      chk("err.err", 32'(err), 32'(v_err.e_err));
      chk("err.done", 32'(done), 32'(v_err.e_done));
      chk("err.busy", 32'(busy), 32'(v_err.e_busy));
      chk("err.steps", steps, v_err.e_steps);
      chk("err.enabled", 32'(enabled), 32'(v_err.e_en));
      tick();
      chk("err.no_req", 32'(request), 32'd0);

      // reset mid-search while request is high in WAIT_BUSY
      launch("start3");
      mc_ready = 1'b0;
      tick();
      mc_next_enabled = 4'd5;
      mc_next_start   = 8'd11;
      marks_flat      = {8'd10, 8'd3, 8'd2, 8'd1, 8'd0};
      mc_ready        = 1'b1;
      tick();
      chk("mid.limit_tight", 32'(limit), 32'd10);
      tick();
      chk("mid.req_high", 32'(request), 32'd1);
      reset = 1'b0;
      tick();
      chk("mid.request", 32'(request), 32'd0);
      chk("mid.busy", 32'(busy), 32'd0);
      chk("mid.limit", 32'(limit), 32'd12);
      chk("mid.found", 32'(found), 32'd0);
      chk("mid.done", 32'(done), 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mid.idle_req", 32'(request), 32'd0);
         chk("mid.idle_busy", 32'(busy), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
